// File: rtl/pio_switch_irq_ctrl_if.sv
// pio_switch_irq_ctrl_if: Avalon-MM slave bus bundle for the switch PIO.
//   address    2-bit word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  32-bit write data
//   readdata   32-bit registered read data
interface pio_switch_irq_ctrl_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_switch_irq_ctrl.sv
// pio_switch_irq_ctrl: synchronizes, debounces and edge-captures switches, raising a maskable irq.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      Avalon-MM slave (0 = debounced state, 1 = zero, 2 = irqmask, 3 = edgecapture W1C)
//   in_port  raw asynchronous switch levels
//   irq      level interrupt, OR of (edgecapture & irqmask)
module pio_switch_irq_ctrl #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int EDGE_TYPE       = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   pio_switch_irq_ctrl_if.slave bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [WIDTH-1:0]         r_meta, r_sync, r_deb, r_mask, r_edge;
   logic [WIDTH-1:0][CW-1:0] r_cnt;
   logic [31:0]              r_rd;
   logic [WIDTH-1:0]         w_acc, w_set, w_clr;
   logic                     w_wr, w_unused;
   // a bit is accepted when it has disagreed with deb for DEBOUNCE_CYCLES consecutive cycles
   always_comb begin
      w_acc = '0;
      for (int k = 0; k < WIDTH; k++) w_acc[k] = (r_sync[k] != r_deb[k]) && (r_cnt[k] == LAST);
   end
   // r_sync holds the new level of an accepted bit, so it tells rising from falling
   assign w_set    = EDGE_TYPE == 0 ? (w_acc & r_sync) : EDGE_TYPE == 1 ? (w_acc & ~r_sync) : w_acc;
   assign w_wr     = bus.chipselect & ~bus.write_n;
   assign w_clr    = (w_wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
   assign w_unused = ^bus.writedata;
   assign irq      = |(r_edge & r_mask);
   assign bus.readdata = r_rd;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= '0;
         r_sync <= '0;
         r_deb  <= '0;
         r_cnt  <= '0;
         r_mask <= '0;
         r_edge <= '0;
         r_rd   <= '0;
      end else begin
         r_meta <= in_port;
         r_sync <= r_meta;
         for (int k = 0; k < WIDTH; k++)
            r_cnt[k] <= (r_sync[k] == r_deb[k] || w_acc[k]) ? '0 : r_cnt[k] + 1'b1;
         r_deb  <= r_deb ^ w_acc;
         // a new edge overrides a same-cycle clear
         r_edge <= (r_edge & ~w_clr) | w_set;
         if (w_wr && bus.address == 2'd2) r_mask <= bus.writedata[WIDTH-1:0];
         r_rd   <= bus.address == 2'd0 ? 32'(r_deb)  :
                   bus.address == 2'd2 ? 32'(r_mask) :
                   bus.address == 2'd3 ? 32'(r_edge) : '0;
      end
   end
endmodule

// File: tb/tb_pio_switch_irq_ctrl.sv
// tb_pio_switch_irq_ctrl: directed checks of the switch PIO for any/rising/falling edge variants.
module tb_pio_switch_irq_ctrl;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  addr = '0;
   logic        cs = 1'b0;
   logic        wn = 1'b1;
   logic [31:0] wd = '0;
   logic [3:0]  in_port = '0;
   logic        irq_a, irq_r, irq_f;
   int          n_chk = 0;
   int          n_fail = 0;
   pio_switch_irq_ctrl_if b_a ();
   pio_switch_irq_ctrl_if b_r ();
   pio_switch_irq_ctrl_if b_f ();
   assign b_a.address = addr;
   assign b_a.chipselect = cs;
   assign b_a.write_n = wn;
   assign b_a.writedata = wd;
   assign b_r.address = addr;
   assign b_r.chipselect = cs;
   assign b_r.write_n = wn;
   assign b_r.writedata = wd;
   assign b_f.address = addr;
   assign b_f.chipselect = cs;
   assign b_f.write_n = wn;
   assign b_f.writedata = wd;
   pio_switch_irq_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(b_a), .in_port(in_port), .irq(irq_a));
   pio_switch_irq_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_r (
      .clk(clk), .reset_n(reset_n), .bus(b_r), .in_port(in_port), .irq(irq_r));
   pio_switch_irq_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut_f (
      .clk(clk), .reset_n(reset_n), .bus(b_f), .in_port(in_port), .irq(irq_f));
   always #5 clk = ~clk;
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr = a;
      wd = d;
      cs = 1'b1;
      wn = 1'b0;
      step();
      cs = 1'b0;
      wn = 1'b1;
   endtask
   task automatic rd(input logic [1:0] a);
      addr = a;
      step();
   endtask
   initial begin
      step(2);
      chk("rst_rd", b_a.readdata, 32'h0);
      chk("rst_irq", {31'b0, irq_a}, 32'h0);
      reset_n = 1'b1;
      rd(2'd2);
      chk("rst_mask", b_a.readdata, 32'h0);
      rd(2'd3);
      chk("rst_edge", b_a.readdata, 32'h0);
      // stable change 0x0 -> 0x5: deb updates on the 6th edge, visible on the 7th
      addr = 2'd0;
      in_port = 4'h5;
      step(6);
      chk("deb_not_early", b_a.readdata, 32'h0);
      step();
      chk("deb_accept", b_a.readdata, 32'h5);
      rd(2'd3);
      chk("edge_any", b_a.readdata, 32'h5);
      chk("edge_rise_r", b_r.readdata, 32'h5);
      chk("edge_rise_f", b_f.readdata, 32'h0);
      // mask and write-1-to-clear
      wr(2'd2, 32'h1);
      chk("irq_mask1", {31'b0, irq_a}, 32'h1);
      rd(2'd2);
      chk("mask_rd", b_a.readdata, 32'h1);
      wr(2'd3, 32'h1);
      chk("irq_cleared", {31'b0, irq_a}, 32'h0);
      rd(2'd3);
      chk("edge_w1c", b_a.readdata, 32'h4);
      wr(2'd2, 32'h4);
      chk("irq_mask4", {31'b0, irq_a}, 32'h1);
      // glitches: 3 cycles rejected, 4 cycles accepted
      wr(2'd3, 32'hF);
      wr(2'd2, 32'h0);
      chk("irq_off", {31'b0, irq_a}, 32'h0);
      in_port = 4'h7;
      step(3);
      in_port = 4'h5;
      step(8);
      rd(2'd0);
      chk("glitch_deb", b_a.readdata, 32'h5);
      rd(2'd3);
      chk("glitch_edge", b_a.readdata, 32'h0);
      in_port = 4'h7;
      step(4);
      in_port = 4'h5;
      step(10);
      rd(2'd3);
      chk("pulse4_edge", b_a.readdata, 32'h2);
      chk("pulse4_edge_r", b_r.readdata, 32'h2);
      chk("pulse4_edge_f", b_f.readdata, 32'h2);
      rd(2'd0);
      chk("pulse4_deb", b_a.readdata, 32'h5);
      // clear of bit2 lands on the edge where deb[2] falls: the edge wins
      wr(2'd3, 32'hF);
      in_port = 4'h1;
      step(5);
      wr(2'd3, 32'h4);
      rd(2'd3);
      chk("collide_edge", b_a.readdata, 32'h4);
      chk("collide_edge_r", b_r.readdata, 32'h0);
      chk("collide_edge_f", b_f.readdata, 32'h4);
      // falling edge on bit0 only seen by any/falling variants
      wr(2'd3, 32'hF);
      in_port = 4'h0;
      step(8);
      rd(2'd3);
      chk("fall_edge", b_a.readdata, 32'h1);
      chk("fall_edge_r", b_r.readdata, 32'h0);
      chk("fall_edge_f", b_f.readdata, 32'h1);
      rd(2'd0);
      chk("fall_deb", b_a.readdata, 32'h0);
      // asynchronous reset mid-run and mid-debounce
      wr(2'd2, 32'hF);
      chk("irq_pre_rst", {31'b0, irq_a}, 32'h1);
      rd(2'd2);
      chk("mask_pre_rst", b_a.readdata, 32'hF);
      in_port = 4'h5;
      step(3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rd", b_a.readdata, 32'h0);
      chk("async_irq", {31'b0, irq_a}, 32'h0);
      step(2);
      reset_n = 1'b1;
      addr = 2'd0;
      step(6);
      chk("restart_not_early", b_a.readdata, 32'h0);
      step();
      chk("restart_accept", b_a.readdata, 32'h5);
      rd(2'd3);
      chk("restart_edge", b_a.readdata, 32'h5);
      chk("restart_irq", {31'b0, irq_a}, 32'h0);
      // writes to addresses 0/1 are ignored; address 1 reads zero
      wr(2'd0, 32'hF);
      wr(2'd1, 32'hF);
      rd(2'd1);
      chk("addr1_zero", b_a.readdata, 32'h0);
      rd(2'd0);
      chk("addr0_kept", b_a.readdata, 32'h5);
      rd(2'd2);
      chk("mask_kept", b_a.readdata, 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pio_switch_irq_ctrl.md
Name: pio_switch_irq_ctrl

Overview:
- Avalon-MM slave controlling the slide-switch inputs: synchronizes, debounces, edge-captures and raises a maskable interrupt toward the Nios II.
- Replaces polling of the raw switch PIO. Software reads the debounced state, enables per-bit interrupts, and acknowledges edges by write-1-to-clear.

Parameters:
- WIDTH, 4: number of switch inputs (1..32).
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz); must be >= 1.
- EDGE_TYPE, 2: edge that sets a capture bit: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous and active-low
- address  in  2  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  raw asynchronous switch levels
- readdata  out  32  registered read data
- irq  out  1  level interrupt request, active-high

Behaviour:
- Reset (asynchronous, reset_n=0): readdata=0, irq=0. Synchronizer flops, debounced state, all counters, irqmask and edgecapture are all 0.
- Synchronizer: two flops per bit, so sync lags in_port by 2 cycles.
- Debounce: independent counter per bit, width clog2(DEBOUNCE_CYCLES)+1.
  - Count cycles while sync != deb.
  - If sync == deb, clear the counter that cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync still != deb: deb <= sync on the next edge and the counter clears.
  - Latency from a stable in_port change to the deb update is 2+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes deb.
- Edge capture: set edgecapture[i] on the same edge deb[i] changes, when the change matches EDGE_TYPE.
  - Set bits stay set until cleared.
  - A deb change after reset counts as an edge (e.g. switches high at reset produce rising edges).
- Write: occurs when chipselect=1 and write_n=0.
  - Address 2: irqmask <= writedata[WIDTH-1:0].
  - Address 3: for each i with writedata[i]=1, clear edgecapture[i].
  - Addresses 0/1: ignored.
  - If a clear and a new edge hit the same bit in the same cycle, the edge wins (bit stays 1).
- Read: readdata is updated every cycle (independent of chipselect), with 1-cycle latency, from the address sampled at the edge.
  - Address 0: deb.
  - Address 1: 0.
  - Address 2: irqmask.
  - Address 3: edgecapture.
  - Unused upper bits are zero-extended.
- irq = OR over i of (edgecapture[i] AND irqmask[i]). It is combinational from registers only, so it rises in the same cycle the edge bit or mask bit becomes 1.
- Reset mid-debounce: the counter and deb return to 0 immediately and the pending change is discarded. After release, debouncing restarts from scratch.
- Counters never wrap: a counter is cleared on acceptance or on a match, so it stays <= DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=4, EDGE_TYPE=2 unless noted):
- Reset then read address 0/2/3 -> readdata=0x0 each, irq=0. Assert reset_n=0 mid-run -> readdata and irq drop to 0 without waiting for a clock edge.
- in_port 0x0 -> 0x5 held -> deb=0x5 exactly 6 cycles after the change; a read of address 0 returns 0x00000005 on the following cycle; edgecapture=0x5.
- in_port bit0 pulsed high for 3 cycles, then low -> deb stays 0x0, edgecapture stays 0x0; a 4-cycle pulse is accepted and captures the edge.
- irqmask=0x1, edgecapture=0x5 -> irq=1. Write 0x1 to address 3 -> edgecapture=0x4, irq=0. Write irqmask=0x4 -> irq=1 the same cycle the mask register updates.
- Write-1-to-clear on bit2 in the same cycle deb[2] toggles -> edgecapture[2] remains 1.
- EDGE_TYPE=0: in_port 0x1 -> 0x0 -> edgecapture unchanged. EDGE_TYPE=1 with the same stimulus -> edgecapture=0x1.
